// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller: coin encodings, denomination
// values, controller state encoding, default prices and coin helpers.
package vending_pkg;

   localparam int unsigned COIN_W     = 2;
   localparam int unsigned CREDIT_W   = 5;
   localparam int unsigned SUM_W      = 6;
   localparam int unsigned CREDIT_MAX = 31;

   typedef enum logic [COIN_W-1:0] {
      COIN_NONE = 2'b00,
      COIN_1    = 2'b01,
      COIN_5    = 2'b10,
      COIN_10   = 2'b11
   } coin_e;

   localparam logic [CREDIT_W-1:0] VAL_1  = 5'd1;
   localparam logic [CREDIT_W-1:0] VAL_5  = 5'd5;
   localparam logic [CREDIT_W-1:0] VAL_10 = 5'd10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CREDIT   = 2'd1,
      DISPENSE = 2'd2,
      CHANGE   = 2'd3
   } state_e;

   localparam logic [CREDIT_W-1:0] PRICE_0_DEF = 5'd5;
   localparam logic [CREDIT_W-1:0] PRICE_1_DEF = 5'd8;
   localparam logic [CREDIT_W-1:0] PRICE_2_DEF = 5'd12;
   localparam logic [CREDIT_W-1:0] PRICE_3_DEF = 5'd15;

   // Monetary value of a coin code
   function automatic logic [CREDIT_W-1:0] coin_value(input logic [COIN_W-1:0] c);
      logic [CREDIT_W-1:0] v;
      unique case (c)
         COIN_1:  v = VAL_1;
         COIN_5:  v = VAL_5;
         COIN_10: v = VAL_10;
         default: v = '0;
      endcase
      return v;
   endfunction

   // Largest denomination not exceeding the given credit
   function automatic logic [COIN_W-1:0] change_coin_for(input logic [CREDIT_W-1:0] credit);
      logic [COIN_W-1:0] c;
      if (credit >= VAL_10)      c = COIN_10;
      else if (credit >= VAL_5)  c = COIN_5;
      else if (credit != '0)     c = COIN_1;
      else                       c = COIN_NONE;
      return c;
   endfunction

endpackage

// File: rtl/vending_controller_if.sv
// Customer-side and actuator-side signal bundle of the vending controller.
// slave  : the controller (consumes coin/selection inputs, drives actuators)
// master : the environment (coin acceptor, buttons, actuator sinks)
interface vending_controller_if;
   import vending_pkg::*;

   logic [COIN_W-1:0]   coin_in;
   logic [1:0]          product_sel;
   logic                select_valid;
   logic                cancel;
   logic [CREDIT_W-1:0] credit;
   logic                dispense;
   logic [1:0]          product_out;
   logic [COIN_W-1:0]   change_coin;
   logic                coin_reject;
   logic                insufficient;
   logic                busy;

   modport slave (
      input  coin_in, product_sel, select_valid, cancel,
      output credit, dispense, product_out, change_coin,
             coin_reject, insufficient, busy
   );

   modport master (
      output coin_in, product_sel, select_valid, cancel,
      input  credit, dispense, product_out, change_coin,
             coin_reject, insufficient, busy
   );
endinterface

// File: rtl/vending_controller_coin_edge_detect.sv
// Coin insertion edge detector.
// clk, rst_n : clock, async active-low reset
// i_coin     : raw coin acceptor level
// o_edge_c   : strobe, coin present now and absent last cycle
// o_value_c  : decoded value of i_coin
module coin_edge_detect
   import vending_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [COIN_W-1:0]   i_coin,
   output logic                o_edge_c,
   output logic [CREDIT_W-1:0] o_value_c
);

   logic [COIN_W-1:0] r_coin_prev;

   // Previous coin level, tracked every cycle regardless of controller state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_coin_prev <= COIN_W'(COIN_NONE);
      else        r_coin_prev <= i_coin;
   end

   assign o_edge_c  = (i_coin != COIN_W'(COIN_NONE)) && (r_coin_prev == COIN_W'(COIN_NONE));
   assign o_value_c = coin_value(i_coin);

endmodule

// File: rtl/vending_controller.sv
// Vending machine sequencer: holds customer credit, credits coin edges,
// evaluates selections against prices, pulses dispense, then pays out the
// remaining credit as alternating change-coin / gap cycles.
// clk   : system clock
// reset : async active-low reset
// bus   : slave side of vending_controller_if (coin/selection in, actuators out)
module vending_controller
   import vending_pkg::*;
#(
   parameter logic [CREDIT_W-1:0] PRICE_0 = PRICE_0_DEF,
   parameter logic [CREDIT_W-1:0] PRICE_1 = PRICE_1_DEF,
   parameter logic [CREDIT_W-1:0] PRICE_2 = PRICE_2_DEF,
   parameter logic [CREDIT_W-1:0] PRICE_3 = PRICE_3_DEF
)(
   input  logic                 clk,
   input  logic                 reset,
   vending_controller_if.slave  bus
);

   state_e              r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic                r_dispense;
   logic [1:0]          r_product_out;
   logic [COIN_W-1:0]   r_change_coin;
   logic                r_coin_reject;
   logic                r_insufficient;
   logic                r_busy;
   logic                r_emit_phase;    // current CHANGE cycle is an emit cycle

   logic                w_coin_edge;
   logic [CREDIT_W-1:0] w_coin_value;
   logic [CREDIT_W-1:0] w_price;
   logic [SUM_W-1:0]    w_sum;
   logic                w_fits;
   logic [COIN_W-1:0]   w_chg_coin;
   logic [CREDIT_W-1:0] w_chg_value;

   coin_edge_detect u_coin_edge (
      .clk       (clk),
      .rst_n     (reset),
      .i_coin    (bus.coin_in),
      .o_edge_c  (w_coin_edge),
      .o_value_c (w_coin_value)
   );

   // Price of the product currently on the selection lines
   always_comb begin
      w_price = PRICE_0;
      unique case (bus.product_sel)
         2'b00: w_price = PRICE_0;
         2'b01: w_price = PRICE_1;
         2'b10: w_price = PRICE_2;
         2'b11: w_price = PRICE_3;
         default: w_price = PRICE_0;
      endcase
   end

   // Widened sum so an overflowing coin is detected instead of wrapping
   assign w_sum       = SUM_W'(r_credit) + SUM_W'(w_coin_value);
   assign w_fits      = (w_sum <= SUM_W'(CREDIT_MAX));
   assign w_chg_coin  = change_coin_for(r_credit);
   assign w_chg_value = coin_value(w_chg_coin);

   // Controller FSM with registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= IDLE;
         r_credit       <= '0;
         r_dispense     <= 1'b0;
         r_product_out  <= 2'b00;
         r_change_coin  <= COIN_W'(COIN_NONE);
         r_coin_reject  <= 1'b0;
         r_insufficient <= 1'b0;
         r_busy         <= 1'b0;
         r_emit_phase   <= 1'b0;
      end else begin
         r_dispense     <= 1'b0;
         r_product_out  <= 2'b00;
         r_change_coin  <= COIN_W'(COIN_NONE);
         r_coin_reject  <= 1'b0;
         r_insufficient <= 1'b0;

         unique case (r_state)
            IDLE: begin
               r_insufficient <= bus.select_valid;
               if (w_coin_edge) begin
                  if (w_fits) begin
                     r_credit <= r_credit + w_coin_value;
                     r_state  <= CREDIT;
                  end else begin
                     r_coin_reject <= 1'b1;
                  end
               end
            end

            CREDIT: begin
               if (bus.cancel) begin
                  // Refund starts immediately: first coin goes out next cycle
                  r_coin_reject <= w_coin_edge;
                  r_state       <= CHANGE;
                  r_busy        <= 1'b1;
                  r_change_coin <= w_chg_coin;
                  r_credit      <= r_credit - w_chg_value;
                  r_emit_phase  <= 1'b1;
               end else if (bus.select_valid) begin
                  r_coin_reject <= w_coin_edge;
                  if (r_credit >= w_price) begin
                     r_credit      <= r_credit - w_price;
                     r_dispense    <= 1'b1;
                     r_product_out <= bus.product_sel;
                     r_busy        <= 1'b1;
                     r_state       <= DISPENSE;
                  end else begin
                     r_insufficient <= 1'b1;
                  end
               end else if (w_coin_edge) begin
                  if (w_fits) r_credit      <= r_credit + w_coin_value;
                  else        r_coin_reject <= 1'b1;
               end
            end

            DISPENSE: begin
               r_coin_reject <= w_coin_edge;
               if (r_credit == '0) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state       <= CHANGE;
                  r_change_coin <= w_chg_coin;
                  r_credit      <= r_credit - w_chg_value;
                  r_emit_phase  <= 1'b1;
               end
            end

            CHANGE: begin
               r_coin_reject <= w_coin_edge;
               if (r_emit_phase) begin
                  r_emit_phase <= 1'b0;
               end else if (r_credit == '0) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_change_coin <= w_chg_coin;
                  r_credit      <= r_credit - w_chg_value;
                  r_emit_phase  <= 1'b1;
               end
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.credit       = r_credit;
   assign bus.dispense     = r_dispense;
   assign bus.product_out  = r_product_out;
   assign bus.change_coin  = r_change_coin;
   assign bus.coin_reject  = r_coin_reject;
   assign bus.insufficient = r_insufficient;
   assign bus.busy         = r_busy;

endmodule

// File: tb/tb_vending_controller.sv
// Self-checking bench for vending_controller with a transaction-level model.
module tb_vending_controller;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   vending_controller_if bus();

   vending_controller dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [4:0] credit;
      logic       disp;
      logic [1:0] prod;
      logic [1:0] chg;
      logic       rej;
      logic       ins;
      logic       busy;
   } out_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: credit as an integer plus a queue of pre-computed
   // output cycles while the machine is committed to a payout.
   int         m_credit;
   logic [1:0] m_prev;
   out_t       m_q[$];
   out_t       m_exp;
   int         prices[4] = '{5, 8, 12, 15};

   function automatic out_t got();
      return {bus.credit, bus.dispense, bus.product_out, bus.change_coin,
              bus.coin_reject, bus.insufficient, bus.busy};
   endfunction

   function automatic int coin_val(input logic [1:0] c);
      case (c)
         2'b01:   return 1;
         2'b10:   return 5;
         2'b11:   return 10;
         default: return 0;
      endcase
   endfunction

   function automatic void model_reset();
      m_credit = 0;
      m_prev   = 2'b00;
      m_q.delete();
      m_exp    = '0;
   endfunction

   // Greedy payout: each coin is one cycle, followed by one gap cycle
   function automatic void queue_change();
      int c;
      out_t r;
      c = m_credit;
      while (c > 0) begin
         int d;
         d = (c >= 10) ? 10 : (c >= 5) ? 5 : 1;
         c -= d;
         r = '0; r.credit = 5'(c); r.busy = 1'b1;
         r.chg = (d == 10) ? 2'b11 : (d == 5) ? 2'b10 : 2'b01;
         m_q.push_back(r);
         r.chg = 2'b00;
         m_q.push_back(r);
      end
      m_q.push_back('0);
      m_credit = 0;
   endfunction

   function automatic void model_step(input logic [1:0] coin, input logic [1:0] sel,
                                      input logic sv, input logic cn);
      bit   cedge;
      out_t e;
      int   v;
      cedge  = (coin != 2'b00) && (m_prev == 2'b00);
      m_prev = coin;
      v      = coin_val(coin);
      e      = '0;
      if (m_q.size() != 0) begin
         e = m_q.pop_front();
         e.rej = cedge;
      end else if (m_credit == 0) begin
         e.ins = sv;
         if (cedge) m_credit = v;
         e.credit = 5'(m_credit);
      end else if (cn) begin
         queue_change();
         e = m_q.pop_front();
         e.rej = cedge;
      end else if (sv) begin
         e.rej = cedge;
         if (prices[sel] > m_credit) begin
            e.ins = 1'b1;
            e.credit = 5'(m_credit);
         end else begin
            m_credit -= prices[sel];
            e.disp = 1'b1; e.prod = sel; e.busy = 1'b1;
            e.credit = 5'(m_credit);
            queue_change();
         end
      end else begin
         if (cedge) begin
            if (m_credit + v <= 31) m_credit += v;
            else                    e.rej = 1'b1;
         end
         e.credit = 5'(m_credit);
      end
      m_exp = e;
   endfunction

   // One clock of stimulus; model advances on the same edge
   task automatic tick(input logic [1:0] coin, input logic [1:0] sel,
                       input logic sv, input logic cn);
      bus.coin_in = coin; bus.product_sel = sel;
      bus.select_valid = sv; bus.cancel = cn;
      @(posedge clk);
      model_step(coin, sel, sv, cn);
      #1;
      bus.select_valid = 1'b0; bus.cancel = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.coin_in = 2'b00; bus.product_sel = 2'b00;
      bus.select_valid = 1'b0; bus.cancel = 1'b0;
      model_reset();
      #3;
      n_checks++;
      if (got() !== out_t'('0)) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h", got(), out_t'('0));
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_exact_purchase();
      // {coin, sel, select_valid, cancel}
      logic [5:0] st[7] = '{6'b11_00_00, 6'b00_00_00, 6'b10_00_00, 6'b00_00_00,
                            6'b00_11_10, 6'b00_00_00, 6'b00_00_00};
      for (int i = 0; i < 7; i++) begin
         tick(st[i][5:4], st[i][3:2], st[i][1], st[i][0]);
         n_checks++;
         if (got() !== m_exp) begin
            n_fail++;
            $display("FAIL exact_purchase step %0d: got %h expected %h", i, got(), m_exp);
         end
         if (i == 4) begin
            n_checks++;
            if ({bus.dispense, bus.product_out, bus.credit} !== {1'b1, 2'b11, 5'd0}) begin
               n_fail++;
               $display("FAIL exact_purchase_dispense: got %b expected %b",
                        {bus.dispense, bus.product_out, bus.credit}, {1'b1, 2'b11, 5'd0});
            end
         end
      end
   endtask

   task automatic test_change_sequence();
      logic [5:0] st[12] = '{6'b11_00_00, 6'b00_00_00, 6'b11_00_00, 6'b00_00_00,
                             6'b00_01_10, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
      logic [1:0] chg_exp[6] = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
      for (int i = 0; i < 12; i++) begin
         tick(st[i][5:4], st[i][3:2], st[i][1], st[i][0]);
         n_checks++;
         if (got() !== m_exp) begin
            n_fail++;
            $display("FAIL change_seq step %0d: got %h expected %h", i, got(), m_exp);
         end
         if (i == 4) begin
            n_checks++;
            if (bus.credit !== 5'd12) begin
               n_fail++;
               $display("FAIL change_seq_credit: got %0d expected 12", bus.credit);
            end
         end
         if (i >= 5 && i <= 10) begin
            n_checks++;
            if (bus.change_coin !== chg_exp[i-5]) begin
               n_fail++;
               $display("FAIL change_seq_coin %0d: got %b expected %b", i-5, bus.change_coin, chg_exp[i-5]);
            end
         end
      end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.credit !== 5'd0) begin
         n_fail++;
         $display("FAIL change_seq_idle: got busy=%b credit=%0d expected busy=0 credit=0", bus.busy, bus.credit);
      end
   endtask

   task automatic test_insufficient();
      logic [5:0] st[9] = '{6'b01_00_00, 6'b0, 6'b01_00_00, 6'b0, 6'b01_00_00, 6'b0,
                            6'b01_00_00, 6'b0, 6'b00_00_10};
      for (int i = 0; i < 9; i++) begin
         tick(st[i][5:4], st[i][3:2], st[i][1], st[i][0]);
         n_checks++;
         if (got() !== m_exp) begin
            n_fail++;
            $display("FAIL insufficient step %0d: got %h expected %h", i, got(), m_exp);
         end
      end
      n_checks++;
      if ({bus.insufficient, bus.credit, bus.busy, bus.dispense} !== {1'b1, 5'd4, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL insufficient_pulse: got %b expected %b",
                  {bus.insufficient, bus.credit, bus.busy, bus.dispense}, {1'b1, 5'd4, 1'b0, 1'b0});
      end
      tick(2'b00, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick(2'b00, 2'b00, 1'b0, 1'b0);
         n_checks++;
         if (got() !== m_exp) begin
            n_fail++;
            $display("FAIL insufficient_drain step %0d: got %h expected %h", i, got(), m_exp);
         end
      end
   endtask

   task automatic test_overflow();
      logic [5:0] st[15] = '{6'b11_00_00, 6'b0, 6'b11_00_00, 6'b0, 6'b10_00_00, 6'b0,
                             6'b11_00_00, 6'b0, 6'b10_00_00, 6'b0, 6'b01_00_00, 6'b0,
                             6'b01_00_00, 6'b0, 6'b00_00_01};
      for (int i = 0; i < 15; i++) begin
         tick(st[i][5:4], st[i][3:2], st[i][1], st[i][0]);
         n_checks++;
         if (got() !== m_exp) begin
            n_fail++;
            $display("FAIL overflow step %0d: got %h expected %h", i, got(), m_exp);
         end
         if (i == 6 || i == 12) begin
            n_checks++;
            if ({bus.coin_reject, bus.credit} !== {1'b1, (i == 6) ? 5'd25 : 5'd31}) begin
               n_fail++;
               $display("FAIL overflow_reject step %0d: got %b expected %b", i,
                        {bus.coin_reject, bus.credit}, {1'b1, (i == 6) ? 5'd25 : 5'd31});
            end
         end
      end
      for (int i = 0; i < 9; i++) begin
         tick(2'b00, 2'b00, 1'b0, 1'b0);
         n_checks++;
         if (got() !== m_exp) begin
            n_fail++;
            $display("FAIL overflow_drain step %0d: got %h expected %h", i, got(), m_exp);
         end
      end
   endtask

   task automatic test_cancel_and_coin();
      logic [5:0] st[13] = '{6'b10_00_00, 6'b0, 6'b01_00_00, 6'b0, 6'b01_00_00, 6'b0,
                             6'b00_00_11, 6'b01_00_00, 6'b01_00_00, 6'b01_00_00,
                             6'b0, 6'b0, 6'b0};
      logic [1:0] chg_exp[6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
      int rejects = 0;
      int disps   = 0;
      for (int i = 0; i < 13; i++) begin
         tick(st[i][5:4], st[i][3:2], st[i][1], st[i][0]);
         n_checks++;
         if (got() !== m_exp) begin
            n_fail++;
            $display("FAIL cancel step %0d: got %h expected %h", i, got(), m_exp);
         end
         if (i >= 6) begin
            rejects += int'(bus.coin_reject);
            disps   += int'(bus.dispense);
         end
         if (i >= 6 && i <= 11) begin
            n_checks++;
            if (bus.change_coin !== chg_exp[i-6]) begin
               n_fail++;
               $display("FAIL cancel_coin %0d: got %b expected %b", i-6, bus.change_coin, chg_exp[i-6]);
            end
         end
      end
      n_checks++;
      if (rejects != 1 || disps != 0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel_summary: got rejects=%0d dispenses=%0d busy=%b expected 1 0 0",
                  rejects, disps, bus.busy);
      end
   endtask

   task automatic test_reset_mid_change();
      logic [5:0] st[10] = '{6'b11_00_00, 6'b0, 6'b10_00_00, 6'b0, 6'b01_00_00, 6'b0,
                             6'b00_00_10, 6'b0, 6'b0, 6'b0};
      for (int i = 0; i < 10; i++) begin
         tick(st[i][5:4], st[i][3:2], st[i][1], st[i][0]);
         n_checks++;
         if (got() !== m_exp) begin
            n_fail++;
            $display("FAIL reset_mid step %0d: got %h expected %h", i, got(), m_exp);
         end
      end
      n_checks++;
      if ({bus.change_coin, bus.credit} !== {2'b01, 5'd0}) begin
         n_fail++;
         $display("FAIL reset_mid_second_coin: got %b expected %b", {bus.change_coin, bus.credit}, {2'b01, 5'd0});
      end
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (got() !== out_t'('0)) begin
         n_fail++;
         $display("FAIL reset_mid_clear: got %h expected %h", got(), out_t'('0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(2'b00, 2'b00, 1'b0, 1'b0);
         n_checks++;
         if (got() !== m_exp) begin
            n_fail++;
            $display("FAIL reset_mid_after step %0d: got %h expected %h", i, got(), m_exp);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] coin = 2'b00;
      int hold = 0;
      for (int i = 0; i < 600; i++) begin
         logic [1:0] sel;
         logic sv, cn;
         if (hold == 0) begin
            coin = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            hold = int'($urandom_range(1, 3));
         end
         hold--;
         sel = 2'($urandom_range(0, 3));
         sv  = ($urandom_range(0, 5) == 0);
         cn  = ($urandom_range(0, 19) == 0);
         tick(coin, sel, sv, cn);
         n_checks++;
         if (got() !== m_exp) begin
            n_fail++;
            $display("FAIL random step %0d: got %h expected %h", i, got(), m_exp);
         end
      end
      tick(2'b00, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         tick(2'b00, 2'b00, 1'b0, 1'b0);
         n_checks++;
         if (got() !== m_exp) begin
            n_fail++;
            $display("FAIL random_drain step %0d: got %h expected %h", i, got(), m_exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_exact_purchase();
      test_change_sequence();
      test_insufficient();
      test_overflow();
      test_cancel_and_coin();
      test_reset_mid_change();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
